// File: rtl/csync_pkg.sv
// Shared types, default thresholds and helpers for the composite-sync decoder.
package csync_pkg;

    // Default timing thresholds, in ce_pix ticks unless noted.
    localparam int DEF_CNT_W      = 12;
    localparam int DEF_LN_W       = 10;
    localparam int DEF_VS_MIN_RUN = 256;
    localparam int DEF_LOCK_LINES = 4;
    localparam int DEF_TOL        = 2;

    // State encodings kept as plain constants so older tools can use them too.
    localparam logic [0:0] ST_LINE_C  = 1'b0;
    localparam logic [0:0] ST_VSYNC_C = 1'b1;

    typedef enum logic [0:0] {
        ST_LINE  = ST_LINE_C,
        ST_VSYNC = ST_VSYNC_C
    } state_t;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/sync_run_counter.sv
// Input conditioning: 2-flop synchronizer, ce_pix edge detect and a saturating
// run-length counter that measures how long the synchronized level has held.
module sync_run_counter
    import csync_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic             i_csync_n,
    output logic             o_s,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_run_cnt
);

    logic [1:0]       r_sync;
    logic             r_s_prev;
    logic [CNT_W-1:0] r_run_cnt;
    logic             w_s;
    logic             w_edge;

    assign w_s    = r_sync[1];
    assign w_edge = i_ce & (w_s ^ r_s_prev);

    // Two-stage synchronizer; idles high so reset never fakes a sync edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_csync_n};
        end
    end

    // Previous level and run length advance only on pixel ticks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s_prev  <= 1'b1;
            r_run_cnt <= '0;
        end else if (i_ce) begin
            r_s_prev <= w_s;
            if (w_edge) begin
                r_run_cnt <= CNT_W'(1);
            end else begin
                r_run_cnt <= CNT_W'(sat_inc(32'(r_run_cnt), CNT_W));
            end
        end
    end

    assign o_s       = w_s;
    assign o_rise    = w_edge & w_s;
    assign o_fall    = w_edge & ~w_s;
    assign o_run_cnt = r_run_cnt;

endmodule

// File: rtl/csync_decoder.sv
// Composite-sync decoder: splits csync_n = ~(HS ^ VS) into positive HSync and
// VSync pulses, measures line period and lines per frame, and flags lock.
module csync_decoder
    import csync_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LN_W       = DEF_LN_W,
    parameter int VS_MIN_RUN = DEF_VS_MIN_RUN,
    parameter int LOCK_LINES = DEF_LOCK_LINES,
    parameter int TOL        = DEF_TOL
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             csync_n,
    output logic             hs_out,
    output logic             vs_out,
    output logic [CNT_W-1:0] line_len,
    output logic [LN_W-1:0]  frame_lines,
    output logic             locked
);

    localparam int               MW       = $clog2(LOCK_LINES + 1);
    localparam logic [MW-1:0]    LOCK_C   = MW'(LOCK_LINES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
    // run_cnt holds the ticks already spent at the level, so the threshold
    // tick itself is the VS_MIN_RUN-th consecutive tick at that level.
    localparam logic [CNT_W-1:0] RUN_THR  = CNT_W'(VS_MIN_RUN - 1);

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_run_cnt;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_hs_rise;
    logic             w_to_vsync;
    logic             w_run_thr;

    logic             r_hs_out;
    logic             r_vs_out;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_line_len;
    logic [MW-1:0]    r_match_cnt;
    logic             r_armed;
    logic [LN_W-1:0]  r_line_cnt;
    logic [LN_W-1:0]  r_frame_lines;

    logic             w_period_sat;
    logic [CNT_W-1:0] w_abs_diff;
    logic             w_period_good;
    logic [MW-1:0]    w_match_inc;

    sync_run_counter #(
        .CNT_W (CNT_W)
    ) u_sync_run (
        .i_clk     (clk_sys),
        .i_reset   (reset),
        .i_ce      (ce_pix),
        .i_csync_n (csync_n),
        .o_s       (w_s),
        .o_rise    (w_rise),
        .o_fall    (w_fall),
        .o_run_cnt (w_run_cnt)
    );

    // An edge on the threshold tick restarts the run, so it blocks the transition.
    assign w_run_thr = ce_pix & ~(w_rise | w_fall) & (w_run_cnt == RUN_THR);

    // Next state and the per-state definition of a line start.
    always_comb begin
        w_state_next = r_state;
        w_hs_rise    = 1'b0;
        w_to_vsync   = 1'b0;
        case (r_state)
            ST_LINE: begin
                w_hs_rise = w_fall;
                if (w_run_thr && !w_s) begin
                    w_state_next = ST_VSYNC;
                    w_to_vsync   = 1'b1;
                end
            end
            ST_VSYNC: begin
                // HSync is inverted while VS is active: pulses show as highs.
                w_hs_rise = w_rise;
                if (w_run_thr && w_s) begin
                    w_state_next = ST_LINE;
                end
            end
            default: begin
                w_state_next = ST_LINE;
            end
        endcase
    end

    // Period comparison against the last latched line length.
    always_comb begin
        w_period_sat = (r_period_cnt == CNT_MAX);
        if (r_period_cnt >= r_line_len) begin
            w_abs_diff = r_period_cnt - r_line_len;
        end else begin
            w_abs_diff = r_line_len - r_period_cnt;
        end
        // A zero line_len means no reference yet: the first real period sets it.
        w_period_good = !w_period_sat && ((r_line_len == '0) || (w_abs_diff <= TOL_C));
        w_match_inc   = (r_match_cnt == LOCK_C) ? r_match_cnt : (r_match_cnt + MW'(1));
    end

    // FSM state and the recovered sync outputs, all registered on pixel ticks.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= ST_LINE;
            r_hs_out <= 1'b0;
            r_vs_out <= 1'b0;
        end else if (ce_pix) begin
            r_state  <= w_state_next;
            r_hs_out <= (w_state_next == ST_VSYNC) ? w_s : ~w_s;
            r_vs_out <= (w_state_next == ST_VSYNC);
        end
    end

    // Line period measurement and lock qualification.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_period_cnt <= '0;
            r_line_len   <= '0;
            r_match_cnt  <= '0;
            r_armed      <= 1'b0;
        end else if (ce_pix) begin
            if (w_hs_rise) begin
                r_period_cnt <= CNT_W'(1);
                if (!r_armed) begin
                    // The count since reset is not a real line, so it only starts timing.
                    r_armed <= 1'b1;
                end else begin
                    if (!w_period_sat) begin
                        r_line_len <= r_period_cnt;
                    end
                    r_match_cnt <= w_period_good ? w_match_inc : '0;
                end
            end else begin
                r_period_cnt <= CNT_W'(sat_inc(32'(r_period_cnt), CNT_W));
                // No sync for a full counter span: drop lock straight away.
                if (w_period_sat) begin
                    r_match_cnt <= '0;
                end
            end
        end
    end

    // Lines per frame, latched when VSync is recognised.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_line_cnt    <= '0;
            r_frame_lines <= '0;
        end else if (ce_pix) begin
            if (w_to_vsync) begin
                r_frame_lines <= r_line_cnt;
                r_line_cnt    <= '0;
            end else if (w_hs_rise) begin
                r_line_cnt <= LN_W'(sat_inc(32'(r_line_cnt), LN_W));
            end
        end
    end

    assign hs_out      = r_hs_out;
    assign vs_out      = r_vs_out;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign locked      = (r_match_cnt == LOCK_C);

endmodule

// File: tb/tb_csync_decoder.sv
// Directed bench for csync_decoder with VS_MIN_RUN=64; pulse widths are
// scoreboarded, register-style outputs are checked at line boundaries.
module tb_csync_decoder;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ce_pix  = 1'b1;
    logic        csync_n = 1'b1;
    logic        hs_out;
    logic        vs_out;
    logic [11:0] line_len;
    logic [9:0]  frame_lines;
    logic        locked;

    int n_checks = 0;
    int n_errors = 0;
    int rate     = 1;
    bit mon_en   = 1'b0;
    bit vs_en    = 1'b0;
    bit edge_en  = 1'b0;

    int   hs_q[$];
    int   vs_q[$];
    int   hs_w = 0;
    int   vs_w = 0;
    logic hs_prev = 1'b0;
    logic vs_prev = 1'b0;
    logic ce_seen = 1'b0;

    always #5 clk_sys = ~clk_sys;

    csync_decoder #(
        .VS_MIN_RUN (64)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .csync_n     (csync_n),
        .hs_out      (hs_out),
        .vs_out      (vs_out),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_tick(input logic lvl);
        for (int j = 0; j < rate; j++) begin
            csync_n = lvl;
            ce_pix  = (j == 0);
            @(negedge clk_sys);
        end
    endtask

    task automatic drive_run(input logic lvl, input int n);
        for (int k = 0; k < n; k++) drive_tick(lvl);
    endtask

    // Normal line: 10-tick low sync pulse, then high for the rest of the period.
    task automatic normal_line(input int period, input bit expect_pulse);
        if (expect_pulse) hs_q.push_back(10 * rate);
        drive_run(1'b0, 10);
        drive_run(1'b1, period - 10);
    endtask

    // VSync line: HS and VS both high cancel, so the line is high 10 then low.
    task automatic vs_line();
        drive_run(1'b1, 10);
        drive_run(1'b0, 90);
    endtask

    task automatic chk_line(input string tag, input int exp_len, input bit exp_lock);
        chk({tag, "_line_len"}, 32'(line_len), 32'(exp_len));
        chk({tag, "_locked"}, 32'(locked), 32'(exp_lock));
    endtask

    always @(posedge clk_sys) ce_seen <= ce_pix;

    // Output monitor: pulse widths against the scoreboard, edges only after ce ticks.
    always @(negedge clk_sys) begin
        if (edge_en) begin
            if (hs_out !== hs_prev) chk("hs_edge_on_ce", 32'(ce_seen), 32'd1);
            if (vs_out !== vs_prev) chk("vs_edge_on_ce", 32'(ce_seen), 32'd1);
        end
        hs_prev <= hs_out;
        vs_prev <= vs_out;
        if (!mon_en) begin
            hs_w <= 0;
        end else if (hs_out === 1'b1) begin
            hs_w <= hs_w + 1;
        end else if (hs_w != 0) begin
            if (hs_q.size() == 0) chk("hs_unexpected_pulse", 32'(hs_w), 32'd0);
            else chk("hs_width", 32'(hs_w), 32'(hs_q.pop_front()));
            hs_w <= 0;
        end
        if (!vs_en) begin
            vs_w <= 0;
        end else if (vs_out === 1'b1) begin
            vs_w <= vs_w + 1;
        end else if (vs_w != 0) begin
            if (vs_q.size() == 0) chk("vs_unexpected_pulse", 32'(vs_w), 32'd0);
            else chk("vs_width", 32'(vs_w), 32'(vs_q.pop_front()));
            vs_w <= 0;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_hs_out", 32'(hs_out), 32'd0);
        chk("rst_vs_out", 32'(vs_out), 32'd0);
        chk("rst_line_len", 32'(line_len), 32'd0);
        chk("rst_frame_lines", 32'(frame_lines), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        reset   = 1'b0;
        mon_en  = 1'b1;
        vs_en   = 1'b1;
        edge_en = 1'b1;
        $display("step: reset released");

        // 20 normal lines: first fall arms, lock on the 5th fall
        drive_run(1'b1, 20);
        for (int i = 1; i <= 20; i++) begin
            normal_line(100, 1'b1);
            if (i == 4) chk("lock_before_5th", 32'(locked), 32'd0);
            if (i == 5) chk_line("lock_at_5th", 100, 1'b1);
        end
        chk_line("after_20", 100, 1'b1);
        chk("after_20_vs_out", 32'(vs_out), 32'd0);
        chk("after_20_frame_lines", 32'(frame_lines), 32'd0);
        $display("step: 20 lines done");

        // VSync block: 3 inverted lines, vs width 300 ticks
        mon_en = 1'b0;
        hs_q.delete();
        vs_q.push_back(300 * rate);
        for (int i = 0; i < 3; i++) vs_line();
        normal_line(100, 1'b0);
        mon_en = 1'b1;
        for (int i = 2; i <= 7; i++) begin
            normal_line(100, 1'b1);
            if (i == 6) chk("post_vs_lock_early", 32'(locked), 32'd0);
        end
        chk_line("post_vs", 100, 1'b1);
        chk("post_vs_frame_lines", 32'(frame_lines), 32'd21);
        chk("post_vs_vs_out", 32'(vs_out), 32'd0);
        $display("step: vsync block done");

        // Jitter 103: lock drops, then 4 matching lines relock
        normal_line(103, 1'b1);
        normal_line(100, 1'b1);
        chk_line("jit103", 103, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            normal_line(100, 1'b1);
            if (i == 5) chk("jit103_relock_early", 32'(locked), 32'd0);
        end
        chk_line("jit103_relock", 100, 1'b1);
        $display("step: jitter 103 done");

        // Jitter 101: within tolerance
        normal_line(101, 1'b1);
        normal_line(100, 1'b1);
        chk_line("jit101", 101, 1'b1);
        normal_line(100, 1'b1);
        chk_line("jit101_next", 100, 1'b1);
        $display("step: jitter 101 done");

        // csync_n stuck high for 5000 ticks
        hs_q.push_back(10 * rate);
        drive_run(1'b0, 10);
        drive_run(1'b1, 5000);
        chk_line("stuck_high", 100, 1'b0);
        chk("stuck_high_hs_out", 32'(hs_out), 32'd0);
        chk("stuck_high_vs_out", 32'(vs_out), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            normal_line(100, 1'b1);
            if (i == 4) chk("resume_lock_early", 32'(locked), 32'd0);
        end
        chk_line("resume", 100, 1'b1);
        $display("step: stuck high done");

        // Quarter-rate ce_pix: same results in ticks
        rate = 4;
        for (int i = 0; i < 6; i++) normal_line(100, 1'b1);
        chk_line("ce_quarter", 100, 1'b1);
        rate = 1;
        $display("step: quarter rate done");

        // Reset in the middle of a line
        hs_q.push_back(10 * rate);
        drive_run(1'b0, 10);
        drive_run(1'b1, 40);
        reset   = 1'b1;
        csync_n = 1'b1;
        ce_pix  = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        chk("midrst_hs_out", 32'(hs_out), 32'd0);
        chk("midrst_vs_out", 32'(vs_out), 32'd0);
        chk("midrst_line_len", 32'(line_len), 32'd0);
        chk("midrst_frame_lines", 32'(frame_lines), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        drive_run(1'b1, 50);
        for (int i = 1; i <= 5; i++) begin
            normal_line(100, 1'b1);
            if (i == 4) chk("midrst_lock_early", 32'(locked), 32'd0);
        end
        chk_line("midrst_relock", 100, 1'b1);
        $display("step: mid-line reset done");

        drive_run(1'b1, 20);
        chk("hs_queue_drained", 32'(hs_q.size()), 32'd0);
        chk("vs_queue_drained", 32'(vs_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
